wb_buffer: RTL and testbench
============================

WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WB_DEPTH SHALL default to 2 and set the number of dirty-line entries.
REQ-003 Parameter LINE_WORDS SHALL default to 8 and set the number of 32-bit words per line.
REQ-004 Ports, as name / direction / width / meaning:
- clk  in  1  clock
- rst  in  1  async active-high reset
- wb_req  in  1  dcache pushes an evicted dirty line
- wb_addr  in  32  line-aligned line address
- wb_line  in  32*LINE_WORDS  line data, word 0 in the LSBs
- wb_full  out  1  no free entry
- wb_empty  out  1  no entry held
- lk_addr  in  32  dcache miss read address
- lk_hit  out  1  lk_addr word is held in the buffer
- lk_data  out  32  forwarded word
- lk_conflict  out  1  lk_addr line is buffered; the read must wait
- cache_ce, cache_wen  out  1 each  write request to the AXI interface
- cache_waddr  out  32  burst start address
- cache_wdata  out  32  current beat
- cache_wvalid  out  1  beat valid
- cache_wlast  out  1  final beat
- cache_sel  out  4  byte strobes
- cachew_burst_length  out  8  awlen
- cache_burst_type  out  2  burst type
- cache_burst_size  out  3  burst size
- wdata_resp  in  1  beat accepted
- wr_done  in  1  B-channel response received for the burst

Function
REQ-005 Entries SHALL be held in a circular FIFO with head/tail pointers and a count of width clog2(WB_DEPTH+1).
REQ-006 A push (wb_req=1 and wb_full=0) SHALL capture wb_addr/wb_line at the tail in the same cycle.
- A push while wb_full=1 SHALL be ignored.
- wb_full and wb_empty SHALL be registered from count.
REQ-007 A push and a pop in the same cycle SHALL leave count unchanged.
- A push at count==WB_DEPTH in the cycle of a pop SHALL still be ignored, because wb_full is registered.
REQ-008 The drain FSM SHALL have the states IDLE, REQ, DATA and WAIT_B.
REQ-009 IDLE->REQ SHALL occur when wb_empty=0.
- In REQ, cache_ce=cache_wen=1 for exactly one cycle.
- cache_waddr SHALL be the head address.
- cachew_burst_length SHALL be LINE_WORDS-1, cache_burst_type INCR, cache_burst_size 4 bytes.
REQ-010 REQ->DATA SHALL always be taken.
- In DATA: cache_wvalid=1, cache_sel=4'hF, and cache_wdata = head word[beat].
- beat SHALL increment on wdata_resp.
- cache_wlast SHALL be 1 when beat==LINE_WORDS-1.
REQ-011 wdata_resp with beat==LINE_WORDS-1 SHALL go DATA->WAIT_B and deassert cache_wvalid/cache_wlast.
REQ-012 wr_done in WAIT_B SHALL pop the head, reset beat to 0, and go to IDLE.
- The next burst SHALL start no earlier than the cycle after IDLE.
REQ-013 The head entry SHALL remain valid and matchable until its pop.
REQ-014 The lookup SHALL be combinational over all valid entries, comparing lk_addr[31:log2(4*LINE_WORDS)].
- When several entries match, the youngest SHALL win.
REQ-015 Beat counter and pointers SHALL wrap modulo LINE_WORDS and WB_DEPTH.

Reset
REQ-016 Asynchronous reset SHALL set:
- head=tail=count=0 and beat=0, FSM=IDLE
- wb_full=0, wb_empty=1
- all cache_* outputs 0, except burst type INCR and size 4 bytes
- lk_hit=lk_conflict=0, lk_data=0
REQ-017 Reset mid-burst SHALL discard all entries with no further AXI-side activity.
- The downstream AXI interface is reset by the same rst.

Configuration
REQ-018 With macro WB_FORWARD_EN defined:
- lk_hit=1 and lk_data = the matching word, with lk_conflict=0.
REQ-019 Without WB_FORWARD_EN:
- lk_hit=0 and lk_data=0.
- lk_conflict=1 on any line match, and the dcache SHALL stall its read until the match clears.

Structure
REQ-020 The shared defines file SHALL hold the FSM state encodings WB_IDLE/WB_REQ/WB_DATA/WB_WAITB.
- AXBURST/AXSIZE encodings are reused from the same file.
REQ-021 The entry storage plus the youngest-match lookup SHALL be one sub-module, wb_entry_array; FSM and pointers stay in wb_buffer.

Verification
REQ-022 The bench SHALL cover these directed scenarios (all checked with and without WB_FORWARD_EN where lookup is involved):
- Push addr 0x1000_0040, words 0..7 = 0xA0..0xA7, wdata_resp every cycle -> cache_waddr 0x1000_0040, len 7, beats A0..A7, wlast on A7, pop only after wr_done.
- Two pushes back-to-back with WB_DEPTH=2 -> wb_full=1; a third push is ignored; after the first wr_done wb_full=0.
- wdata_resp toggling 1,0,1 -> cache_wdata holds while unaccepted; 8 accepted beats total.
- lk_addr 0x1000_0048 while the entry is buffered -> forward: lk_hit=1, lk_data=0xA2; no forward: lk_conflict=1.
- Two entries with the same line, second line data 0xB* -> forward returns 0xB2.
- rst asserted in DATA at beat 3 -> cache_wvalid=0 immediately, wb_empty=1, no burst after release.

Source files
------------

// File: rtl/wb_buffer_pkg.sv
// Shared definitions for the dcache write-back buffer: drain FSM state
// encodings, AXI burst encodings and a pointer-width helper.
package wb_buffer_pkg;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_REQ   = 2'd1,
    WB_DATA  = 2'd2,
    WB_WAITB = 2'd3
  } wb_state_t;

  localparam logic [1:0] AXBURST_INCR = 2'b01;
  localparam logic [2:0] AXSIZE_4B    = 3'b010;

  // Index width that stays at least one bit for single-entry structures.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_entry_array.sv
// Dirty-line storage for the write-back buffer, with head-word readout for
// the drain burst and a combinational youngest-match lookup over valid entries.
module wb_entry_array
  import wb_buffer_pkg::*;
#(
  parameter int WB_DEPTH   = 2,
  parameter int LINE_WORDS = 8,
  parameter int PTR_W      = 1,
  parameter int CNT_W      = 2,
  parameter int BEAT_W     = 3
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [PTR_W-1:0]        wr_ptr,
  input  logic [31:0]             wr_addr,
  input  logic [32*LINE_WORDS-1:0] wr_line,
  input  logic [PTR_W-1:0]        head,
  input  logic [CNT_W-1:0]        count,
  input  logic [BEAT_W-1:0]       beat,
  output logic [31:0]             head_addr,
  output logic [31:0]             head_word,
  input  logic [31:0]             lk_addr,
  output logic                    lk_match,
  output logic [31:0]             lk_word
);

  localparam int OFF_W = $clog2(4 * LINE_WORDS);

  logic [31:0]                  addr_q [WB_DEPTH];
  logic [LINE_WORDS-1:0][31:0]  line_q [WB_DEPTH];
  logic [OFF_W-3:0]             lk_widx;
  logic                         unused_lk;
  int                           age;
  int                           best_age;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_q[wr_ptr] <= wr_addr;
      line_q[wr_ptr] <= wr_line;
    end
  end

  assign head_addr = addr_q[head];
  assign head_word = line_q[head][beat];
  assign lk_widx   = lk_addr[OFF_W-1:2];
  assign unused_lk = ^lk_addr[1:0];

  // Age is the distance from head; the largest matching age is the youngest entry.
  always_comb begin
    lk_match = 1'b0;
    lk_word  = '0;
    best_age = 0;
    age      = 0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      age = i - int'(head);
      if (age < 0) age = age + WB_DEPTH;
      if (age < int'(count) &&
          addr_q[i][31:OFF_W] == lk_addr[31:OFF_W] &&
          (!lk_match || age > best_age)) begin
        lk_match = 1'b1;
        best_age = age;
        lk_word  = line_q[i][lk_widx];
      end
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer between dcache evictions and the AXI write path: circular
// FIFO of dirty lines drained one INCR burst at a time. Build macro
// WB_FORWARD_EN selects read forwarding; otherwise matching reads get lk_conflict.
module wb_buffer
  import wb_buffer_pkg::*;
#(
  parameter int WB_DEPTH   = 2,
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_req,
  input  logic [31:0]              wb_addr,
  input  logic [32*LINE_WORDS-1:0] wb_line,
  output logic                     wb_full,
  output logic                     wb_empty,
  input  logic [31:0]              lk_addr,
  output logic                     lk_hit,
  output logic [31:0]              lk_data,
  output logic                     lk_conflict,
  output logic                     cache_ce,
  output logic                     cache_wen,
  output logic [31:0]              cache_waddr,
  output logic [31:0]              cache_wdata,
  output logic                     cache_wvalid,
  output logic                     cache_wlast,
  output logic [3:0]               cache_sel,
  output logic [7:0]               cachew_burst_length,
  output logic [1:0]               cache_burst_type,
  output logic [2:0]               cache_burst_size,
  input  logic                     wdata_resp,
  input  logic                     wr_done
);

  localparam int PTR_W  = idx_w(WB_DEPTH);
  localparam int BEAT_W = idx_w(LINE_WORDS);
  localparam int CNT_W  = $clog2(WB_DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(WB_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(WB_DEPTH - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);

  wb_state_t          state, state_next;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count, count_next;
  logic [BEAT_W-1:0]  beat;
  logic               push, pop, beat_acc;
  logic [31:0]        head_addr, head_word, lk_word;
  logic               lk_match;

  assign push     = wb_req && !wb_full;
  assign pop      = (state == WB_WAITB) && wr_done;
  assign beat_acc = (state == WB_DATA) && wdata_resp;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  // Flags are registered from the next count so they always match count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      beat     <= '0;
      wb_full  <= 1'b0;
      wb_empty <= 1'b1;
    end else begin
      count    <= count_next;
      wb_full  <= (count_next == DEPTH_C);
      wb_empty <= (count_next == '0);
      if (push) tail <= (tail == PTR_LAST) ? '0 : tail + PTR_W'(1);
      if (pop)  head <= (head == PTR_LAST) ? '0 : head + PTR_W'(1);
      if (pop)           beat <= '0;
      else if (beat_acc) beat <= (beat == BEAT_LAST) ? '0 : beat + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next          = state;
    cache_ce            = 1'b0;
    cache_wen           = 1'b0;
    cache_waddr         = '0;
    cachew_burst_length = '0;
    cache_wvalid        = 1'b0;
    cache_wlast         = 1'b0;
    cache_wdata         = '0;
    cache_sel           = '0;
    case (state)
      WB_IDLE: if (!wb_empty) state_next = WB_REQ;
      WB_REQ: begin
        cache_ce            = 1'b1;
        cache_wen           = 1'b1;
        cache_waddr         = head_addr;
        cachew_burst_length = 8'(LINE_WORDS - 1);
        state_next          = WB_DATA;
      end
      WB_DATA: begin
        cache_wvalid = 1'b1;
        cache_sel    = 4'hF;
        cache_wdata  = head_word;
        cache_wlast  = (beat == BEAT_LAST);
        if (wdata_resp && beat == BEAT_LAST) state_next = WB_WAITB;
      end
      WB_WAITB: if (wr_done) state_next = WB_IDLE;
      default: state_next = WB_IDLE;
    endcase
  end

  assign cache_burst_type = AXBURST_INCR;
  assign cache_burst_size = AXSIZE_4B;

  wb_entry_array #(
    .WB_DEPTH  (WB_DEPTH),
    .LINE_WORDS(LINE_WORDS),
    .PTR_W     (PTR_W),
    .CNT_W     (CNT_W),
    .BEAT_W    (BEAT_W)
  ) u_entries (
    .clk      (clk),
    .wr_en    (push),
    .wr_ptr   (tail),
    .wr_addr  (wb_addr),
    .wr_line  (wb_line),
    .head     (head),
    .count    (count),
    .beat     (beat),
    .head_addr(head_addr),
    .head_word(head_word),
    .lk_addr  (lk_addr),
    .lk_match (lk_match),
    .lk_word  (lk_word)
  );

`ifdef WB_FORWARD_EN
  assign lk_hit      = lk_match;
  assign lk_data     = lk_word;
  assign lk_conflict = 1'b0;
`else
  logic unused_fwd;
  assign lk_hit      = 1'b0;
  assign lk_data     = '0;
  assign lk_conflict = lk_match;
  assign unused_fwd  = ^lk_word;
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: lookup vectors from a table, drain bursts,
// full handling, toggled beat acceptance and reset mid-burst.
module tb_wb_buffer;
  import wb_buffer_pkg::*;

  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wb_req = 1'b0;
  logic [31:0]     wb_addr = '0;
  logic [32*LW-1:0] wb_line = '0;
  logic            wb_full, wb_empty;
  logic [31:0]     lk_addr = '0;
  logic            lk_hit, lk_conflict;
  logic [31:0]     lk_data;
  logic            cache_ce, cache_wen, cache_wvalid, cache_wlast;
  logic [31:0]     cache_waddr, cache_wdata;
  logic [3:0]      cache_sel;
  logic [7:0]      cachew_burst_length;
  logic [1:0]      cache_burst_type;
  logic [2:0]      cache_burst_size;
  logic            wdata_resp = 1'b0;
  logic            wr_done = 1'b0;

  always #5 clk = ~clk;

  wb_buffer #(.WB_DEPTH(2), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line),
    .wb_full(wb_full), .wb_empty(wb_empty), .lk_addr(lk_addr), .lk_hit(lk_hit),
    .lk_data(lk_data), .lk_conflict(lk_conflict), .cache_ce(cache_ce),
    .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .cache_wvalid(cache_wvalid), .cache_wlast(cache_wlast), .cache_sel(cache_sel),
    .cachew_burst_length(cachew_burst_length), .cache_burst_type(cache_burst_type),
    .cache_burst_size(cache_burst_size), .wdata_resp(wdata_resp), .wr_done(wr_done)
  );

  int checks = 0;
  int failures = 0;
  int exp_req = 0;

  int          req_cnt = 0;
  int          vld_cyc = 0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_len = '0;

  always @(posedge clk) begin
    if (cache_ce && cache_wen) begin
      req_cnt  <= req_cnt + 1;
      req_addr <= cache_waddr;
      req_len  <= cachew_burst_length;
    end
    if (cache_wvalid) vld_cyc <= vld_cyc + 1;
  end

  typedef struct {
    logic [31:0] addr;
    bit          match;
    logic [31:0] word;
  } lk_vec_t;

  lk_vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [32*LW-1:0] mk_line(input logic [31:0] base);
    logic [32*LW-1:0] l;
    for (int w = 0; w < LW; w++) l[w*32 +: 32] = base + 32'(w);
    return l;
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] base);
    @(negedge clk);
    wb_req = 1'b1; wb_addr = a; wb_line = mk_line(base);
    @(negedge clk);
    wb_req = 1'b0;
  endtask

  task automatic run_lookup(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      lk_addr = tbl[i].addr;
      #1;
`ifdef WB_FORWARD_EN
      chk($sformatf("lk%0d_hit", i), lk_hit, tbl[i].match);
      chk($sformatf("lk%0d_data", i), lk_data, tbl[i].match ? tbl[i].word : 32'h0);
      chk($sformatf("lk%0d_conflict", i), lk_conflict, 0);
`else
      chk($sformatf("lk%0d_hit", i), lk_hit, 0);
      chk($sformatf("lk%0d_data", i), lk_data, 0);
      chk($sformatf("lk%0d_conflict", i), lk_conflict, tbl[i].match);
`endif
    end
  endtask

  task automatic wait_wvalid(input string name);
    int n = 0;
    @(negedge clk); #1;
    while (!cache_wvalid && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_wvalid_up"}, cache_wvalid, 1);
    chk({name, "_sel"}, cache_sel, 4'hF);
  endtask

  task automatic drain(input string name, input logic [31:0] exp_addr,
                       input logic [31:0] base, input bit toggle, input bit exp_full_wait);
    int acc = 0;
    int n = 0;
    bit ph = 1'b1;
    wait_wvalid(name);
    chk({name, "_waddr"}, req_addr, exp_addr);
    chk({name, "_len"}, req_len, 8'd7);
    chk({name, "_reqcnt"}, req_cnt, exp_req);
    while (acc < LW && n < 64) begin
      wdata_resp = toggle ? ph : 1'b1;
      ph = ~ph;
      #1;
      chk($sformatf("%s_wvalid%0d", name, n), cache_wvalid, 1);
      chk($sformatf("%s_wdata%0d", name, n), cache_wdata, base + 32'(acc));
      chk($sformatf("%s_wlast%0d", name, n), cache_wlast, acc == LW - 1);
      if (wdata_resp) acc++;
      n++;
      @(negedge clk);
    end
    wdata_resp = 1'b0;
    #1;
    chk({name, "_beats"}, acc, LW);
    chk({name, "_wvalid_down"}, cache_wvalid, 0);
    chk({name, "_wlast_down"}, cache_wlast, 0);
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_nopop_empty"}, wb_empty, 0);
    chk({name, "_nopop_full"}, wb_full, exp_full_wait);
    chk({name, "_no_new_req"}, req_cnt, exp_req);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int snap_req, snap_vld;
    tbl[0]  = '{32'h1000_0048, 1'b1, 32'hA2};
    tbl[1]  = '{32'h1000_0040, 1'b1, 32'hA0};
    tbl[2]  = '{32'h1000_005C, 1'b1, 32'hA7};
    tbl[3]  = '{32'h1000_004B, 1'b1, 32'hA2};
    tbl[4]  = '{32'h1000_0060, 1'b0, 32'h0};
    tbl[5]  = '{32'h1000_0020, 1'b0, 32'h0};
    tbl[6]  = '{32'h2000_0048, 1'b0, 32'h0};
    tbl[7]  = '{32'h1000_0048, 1'b1, 32'hB2};
    tbl[8]  = '{32'h1000_0048, 1'b1, 32'hB2};
    tbl[9]  = '{32'h1000_0054, 1'b1, 32'hB5};
    tbl[10] = '{32'h1000_0048, 1'b0, 32'h0};

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_empty", wb_empty, 1);
    chk("rst_full", wb_full, 0);
    chk("rst_ce", cache_ce, 0);
    chk("rst_wen", cache_wen, 0);
    chk("rst_wvalid", cache_wvalid, 0);
    chk("rst_len", cachew_burst_length, 0);
    chk("rst_btype", cache_burst_type, 2'b01);
    chk("rst_bsize", cache_burst_size, 3'b010);
    chk("rst_lk_hit", lk_hit, 0);
    chk("rst_lk_conflict", lk_conflict, 0);
    chk("rst_lk_data", lk_data, 0);
    rst = 1'b0;

    // Single line, lookups while buffered, full-rate drain
    push(32'h1000_0040, 32'hA0);
    exp_req++;
    run_lookup(0, 6);
    drain("a", 32'h1000_0040, 32'hA0, 1'b0, 1'b0);
    chk("a_popped", wb_empty, 1);

    // Same line twice: youngest copy wins
    push(32'h1000_0040, 32'hA0);
    push(32'h1000_0040, 32'hB0);
    exp_req++;
    run_lookup(7, 7);
    drain("e1", 32'h1000_0040, 32'hA0, 1'b0, 1'b1);
    run_lookup(8, 9);
    exp_req++;
    drain("e2", 32'h1000_0040, 32'hB0, 1'b0, 1'b0);
    run_lookup(10, 10);

    // Back-to-back pushes fill the buffer; third push ignored
    @(negedge clk);
    wb_req = 1'b1; wb_addr = 32'h2000_0000; wb_line = mk_line(32'hC0);
    @(negedge clk);
    #1 chk("b_full_after1", wb_full, 0);
    wb_addr = 32'h2000_0100; wb_line = mk_line(32'hD0);
    @(negedge clk);
    #1 chk("b_full_after2", wb_full, 1);
    wb_addr = 32'h2000_0200; wb_line = mk_line(32'hE0);
    @(negedge clk);
    wb_req = 1'b0;
    #1 chk("b_full_after3", wb_full, 1);
    exp_req++;
    drain("b1", 32'h2000_0000, 32'hC0, 1'b0, 1'b1);
    chk("b1_full_cleared", wb_full, 0);
    chk("b1_not_empty", wb_empty, 0);
    exp_req++;
    drain("b2", 32'h2000_0100, 32'hD0, 1'b0, 1'b0);
    chk("b2_empty", wb_empty, 1);
    repeat (10) @(negedge clk);
    #1 chk("b_third_ignored", req_cnt, exp_req);

    // Beat acceptance toggling 1,0,1,...
    push(32'h3000_0000, 32'hF0);
    exp_req++;
    drain("c", 32'h3000_0000, 32'hF0, 1'b1, 1'b0);
    chk("c_empty", wb_empty, 1);

    // Reset in the middle of a burst at beat 3
    push(32'h1000_0040, 32'hA0);
    lk_addr = 32'h1000_0048;
    wait_wvalid("r");
    repeat (3) begin
      wdata_resp = 1'b1;
      @(negedge clk);
    end
    wdata_resp = 1'b0;
    #1 chk("r_beat3_data", cache_wdata, 32'hA3);
    rst = 1'b1;
    #1;
    chk("r_wvalid_drop", cache_wvalid, 0);
    chk("r_empty", wb_empty, 1);
    chk("r_full", wb_full, 0);
    chk("r_lk_hit", lk_hit, 0);
    chk("r_lk_conflict", lk_conflict, 0);
    snap_req = req_cnt;
    snap_vld = vld_cyc;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("r_no_req_after", req_cnt, snap_req);
    chk("r_no_beats_after", vld_cyc, snap_vld);
    chk("r_still_empty", wb_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
